mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32I pipeline: consumes the EX/MEM register outputs, performs loads and stores over a single-outstanding data bus with a req/gnt/rvalid handshake, and produces writeback data for the MEM/WB register. While an access is outstanding it holds `stall_o` to freeze the EX/MEM register and all upstream stages. Non-memory instructions pass through with one-cycle latency.

## Interface
- `MAX_WAIT`, 255: cycles in REQ+RESP before the access is aborted with a bus error (8-bit counter).
- `clk`  input  1  clock, rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `opcode_i`  input  7  opcode from EX/MEM
- `funct3_i`  input  3  funct3 from EX/MEM
- `rd_i`  input  5  destination register
- `alu_out_i`  input  32  effective address (mem ops) or result (others)
- `rs2_data_i`  input  32  store data
- `dbus_req_o` / `dbus_we_o`  output  1  bus request / write
- `dbus_addr_o`  output  32  word-aligned address `{addr[31:2],2'b00}`
- `dbus_wdata_o`  output  32  lane-steered store data
- `dbus_be_o`  output  4  byte enables
- `dbus_gnt_i` / `dbus_rvalid_i`  input  1  grant / response valid
- `dbus_rdata_i`  input  32  read data
- `stall_o`  output  1  freeze EX/MEM and upstream (combinational)
- `wb_valid_o` / `wb_we_o`  output  1  writeback valid / register write
- `wb_rd_o`  output  5;  `wb_data_o`  output  32
- `bus_err_o`  output  1  one-cycle watchdog-abort pulse
- `misalign_o`  output  1  one-cycle misaligned-access pulse (see Configuration)

## Operation
- FSM states IDLE, REQ, RESP. Reset: IDLE; every registered output 0.
- IDLE, non-memory op: next edge `wb_valid_o`=1, `wb_data_o`=`alu_out_i`, `wb_rd_o`=`rd_i`, `wb_we_o`=1 for LUI/AUIPC/JAL/JALR/OP/OP-IMM with `rd_i`≠0, else 0.
- IDLE, LOAD (0000011) or STORE (0100011): latch address/data/funct3/rd; go REQ; `dbus_req_o`=1 from next cycle.
- REQ: hold req/we/addr/be/wdata stable until `dbus_gnt_i`; on gnt drop req, go RESP.
- RESP: on `dbus_rvalid_i` (for stores too), go IDLE; next edge `wb_valid_o`=1; loads `wb_we_o`=(rd≠0) with extracted data; stores `wb_we_o`=0.
- `wb_valid_o`, `bus_err_o`, `misalign_o` are single-cycle pulses.
- `stall_o` = (IDLE & mem op & access issued) | REQ | (RESP & ~rvalid).
- Stores: SB be=`1<<addr[1:0]`, wdata byte replicated ×4; SH be=0011/1100 by addr[1], half replicated ×2; SW be=1111. funct3≥3 treated as SW.
- Loads: LB/LBU byte at addr[1:0] sign/zero-extended; LH/LHU half at addr[1]; LW whole word. funct3 3/6/7 treated as LW.
- Watchdog: counter cleared on leaving IDLE; at `MAX_WAIT` in REQ/RESP: `bus_err_o` pulse, `wb_valid_o` with `wb_we_o`=0, go IDLE.

## Timing
- Non-memory latency: 1 cycle.
- Minimum memory latency: accept edge → REQ (gnt same cycle) → RESP (rvalid same cycle) → `wb_valid_o` next edge = 3 cycles.
- rvalid is legal no earlier than the cycle after gnt; rvalid in IDLE or REQ is ignored.
- Stall drops in the rvalid cycle; on that edge EX/MEM advances and the FSM returns to IDLE together, so no instruction is issued twice.
- Reset mid-access: immediate IDLE, req dropped; late rvalid is ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no bus request. Next edge: `misalign_o`=1, `wb_valid_o`=1, `wb_we_o`=0. No stall.
- Undefined: `misalign_o` tied 0; low address bits beyond the access size are ignored (a half uses addr[1]; a word ignores addr[1:0]).

## Structure
- Shared package/define file: opcode constants (LOAD, STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR), funct3 load/store encodings, FSM state encodings.
- Sub-module `lsu_align`, combinational: store lane steering and byte enables, load extraction and extension.

## Test plan
- ADDI result 0x0000_1234, rd=5 → next cycle `wb_valid_o`=1, `wb_we_o`=1, `wb_data_o`=0x1234, no stall.
- SB addr 0x103, rs2=0xAB → `dbus_be_o`=1000, `dbus_wdata_o`=0xABABABAB, `dbus_addr_o`=0x100; with gnt and rvalid immediate, `wb_valid_o` after 3 cycles with `wb_we_o`=0.
- LB addr 0x102, rdata 0x0080_0000 → `wb_data_o`=0xFFFF_FF80; LBU → 0x0000_0080; LH addr 0x102, rdata 0x8001_0000 → 0xFFFF_8001.
- Gnt withheld 4 cycles, rvalid 2 cycles after gnt → req and addr stable throughout, `stall_o` high until the rvalid cycle, one `wb_valid_o`.
- MAX_WAIT=8, no gnt → `bus_err_o` pulse after 8 cycles, `wb_we_o`=0, FSM IDLE; `rst` asserted mid-RESP → all outputs 0 and a late rvalid is ignored.
- `MEM_MISALIGN_TRAP_EN` defined, LW addr 0x101 → no `dbus_req_o`, `misalign_o` pulse, `wb_we_o`=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory stage: opcodes, funct3 encodings,
// FSM states, the data-bus request payload and small decode helpers.
package mem_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dbus_req_t;

    // Register-writing non-memory opcodes.
    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Access-size alignment check; unknown store sizes behave as words.
    function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] a);
        if (f3 == F3_B || (!is_store && f3 == F3_BU)) return 1'b0;
        if (f3 == F3_H || (!is_store && f3 == F3_HU)) return a[0];
        return a != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering: store byte enables/replicated data and load
// byte/half extraction with sign or zero extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      st_funct3_i,
    input  logic [1:0]      st_addr_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [BE_W-1:0] st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_funct3_i)
            F3_B: begin
                st_be_o    = 4'b0001 << st_addr_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            F3_H: begin
                st_be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_addr_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'd0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'd0, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: single-outstanding req/gnt/rvalid data bus with watchdog.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned halves/words instead of issuing.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [BE_W-1:0] dbus_be_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            bus_err_o,
    output logic            misalign_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dbus_req_t        bus_q, bus_d;
    logic             req_q, req_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_addr_q, ld_addr_d;
    logic [4:0]       rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic             bus_err_q, bus_err_d, misalign_q, misalign_d;

    logic            is_store, is_mem, mis_c, issue_c, wd_c;
    logic [BE_W-1:0] st_be;
    logic [XLEN-1:0] st_wdata, ld_data;

    lsu_align u_align (
        .st_funct3_i (funct3_i),
        .st_addr_i   (alu_out_i[1:0]),
        .st_data_i   (rs2_data_i),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (ld_f3_q),
        .ld_addr_i   (ld_addr_q),
        .ld_rdata_i  (dbus_rdata_i),
        .ld_data_o   (ld_data)
    );

    assign is_store = (opcode_i == OPC_STORE);
    assign is_mem   = is_store || (opcode_i == OPC_LOAD);
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_c    = is_mem && is_misaligned(is_store, funct3_i, alu_out_i[1:0]);
`else
    assign mis_c    = 1'b0;
`endif
    assign issue_c  = (state_q == ST_IDLE) && is_mem && !mis_c;
    assign wd_c     = (cnt_q == CNT_W'(MAX_WAIT - 1));
    assign stall_o  = issue_c || (state_q == ST_REQ) || (state_q == ST_RESP && !dbus_rvalid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bus_q      <= '0;
            req_q      <= 1'b0;
            ld_f3_q    <= '0;
            ld_addr_q  <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_q      <= bus_d;
            req_q      <= req_d;
            ld_f3_q    <= ld_f3_d;
            ld_addr_q  <= ld_addr_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
        end
    end

    // Watchdog wins in REQ; a response in RESP wins over the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue_c) state_d = ST_REQ;
            ST_REQ:  if (wd_c) state_d = ST_IDLE;
                     else if (dbus_gnt_i) state_d = ST_RESP;
            ST_RESP: if (dbus_rvalid_i || wd_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        bus_d      = bus_q;
        req_d      = req_q;
        ld_f3_d    = ld_f3_q;
        ld_addr_d  = ld_addr_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (issue_c) begin
                    req_d      = 1'b1;
                    bus_d.we   = is_store;
                    bus_d.addr = {alu_out_i[XLEN-1:2], 2'b00};
                    bus_d.wdata = is_store ? st_wdata : '0;
                    bus_d.be   = is_store ? st_be : 4'b1111;
                    ld_f3_d    = funct3_i;
                    ld_addr_d  = alu_out_i[1:0];
                    rd_d       = rd_i;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = !mis_c && writes_rd(opcode_i) && (rd_i != 5'd0);
                    wb_rd_d    = rd_i;
                    wb_data_d  = alu_out_i;
                    misalign_d = mis_c;
                end
            end
            ST_REQ, ST_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (state_q == ST_RESP && dbus_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = !bus_q.we && (rd_q != 5'd0);
                    wb_data_d  = bus_q.we ? '0 : ld_data;
                end else if (wd_c) begin
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    bus_err_d  = 1'b1;
                end else if (state_q == ST_REQ && dbus_gnt_i) begin
                    req_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign dbus_req_o   = req_q;
    assign dbus_we_o    = bus_q.we;
    assign dbus_addr_o  = bus_q.addr;
    assign dbus_wdata_o = bus_q.wdata;
    assign dbus_be_o    = bus_q.be;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign bus_err_o    = bus_err_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (watchdog shortened to 8 cycles).
module tb_mem_stage;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111, BRANCH = 7'b1100011;

    logic        clk = 1'b0, rst = 1'b1;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] alu_out_i = '0, rs2_data_i = '0;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i = 1'b0, dbus_rvalid_i = 1'b0;
    logic [31:0] dbus_rdata_i = '0;
    logic        stall_o, wb_valid_o, wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        bus_err_o, misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
        .alu_out_i(alu_out_i), .rs2_data_i(rs2_data_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    task automatic idle_inputs();
        opcode_i = 7'h00; funct3_i = 3'd0; rd_i = 5'd0; alu_out_i = '0; rs2_data_i = '0;
    endtask

    // Drives one memory instruction through the full handshake, holding it in
    // EX/MEM while stalled, and reports what the bus and writeback showed.
    task automatic mem_access(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                              output logic [31:0] o_data, output logic o_we,
                              output logic [4:0] o_rd, output logic [31:0] o_addr,
                              output logic [31:0] o_wdata, output logic [3:0] o_be,
                              output logic o_dwe, output int n_valid, output int n_unstable,
                              output int n_stall_bad);
        n_valid = 0; n_unstable = 0; n_stall_bad = 0;
        opcode_i = op; funct3_i = f3; rd_i = rd; alu_out_i = addr; rs2_data_i = wdata;
        #1; if (stall_o !== 1'b1) n_stall_bad++;
        @(posedge clk); #1;
        if (dbus_req_o !== 1'b1) n_unstable++;
        if (wb_valid_o === 1'b1) n_valid++;
        o_addr = dbus_addr_o; o_wdata = dbus_wdata_o; o_be = dbus_be_o; o_dwe = dbus_we_o;
        repeat (gnt_wait) begin
            #1; if (stall_o !== 1'b1) n_stall_bad++;
            @(posedge clk); #1;
            if (dbus_req_o !== 1'b1 || dbus_addr_o !== o_addr || dbus_be_o !== o_be ||
                dbus_wdata_o !== o_wdata || dbus_we_o !== o_dwe) n_unstable++;
            if (wb_valid_o === 1'b1) n_valid++;
        end
        dbus_gnt_i = 1'b1;
        #1; if (stall_o !== 1'b1) n_stall_bad++;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
        if (dbus_req_o !== 1'b0) n_unstable++;
        if (wb_valid_o === 1'b1) n_valid++;
        repeat (rv_wait - 1) begin
            #1; if (stall_o !== 1'b1) n_stall_bad++;
            @(posedge clk); #1;
            if (wb_valid_o === 1'b1) n_valid++;
        end
        dbus_rvalid_i = 1'b1; dbus_rdata_i = rdata;
        #1; if (stall_o !== 1'b0) n_stall_bad++;
        @(posedge clk); #1;
        dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
        if (wb_valid_o === 1'b1) n_valid++;
        o_data = wb_data_o; o_we = wb_we_o; o_rd = wb_rd_o;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if ({dbus_req_o, dbus_we_o, dbus_be_o, wb_valid_o, wb_we_o, bus_err_o, misalign_o} !== 10'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {dbus_req_o, dbus_we_o, dbus_be_o, wb_valid_o, wb_we_o, bus_err_o, misalign_o}); end
        n_tests++; if ({dbus_addr_o, dbus_wdata_o, wb_data_o, wb_rd_o} !== 101'd0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h wb %h rd %0d want 0", dbus_addr_o, dbus_wdata_o, wb_data_o, wb_rd_o); end
        n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [6:0]  ops [4] = '{OPIMM, OPIMM, LUI, BRANCH};
        logic [4:0]  rds [4] = '{5'd5, 5'd0, 5'd3, 5'd7};
        logic [31:0] vals[4] = '{32'h0000_1234, 32'h0000_0042, 32'hABCD_E000, 32'h0000_0010};
        logic        wes [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            opcode_i = ops[i]; rd_i = rds[i]; alu_out_i = vals[i];
            #1;
            n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall[%0d]: got %b want 0", i, stall_o); end
            @(posedge clk); #1;
            n_tests++; if ({wb_valid_o, wb_we_o, wb_rd_o, wb_data_o} !== {1'b1, wes[i], rds[i], vals[i]}) begin n_fail++; $display("FAIL alu_wb[%0d]: got v%b we%b rd%0d %h want v1 we%b rd%0d %h", i, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wes[i], rds[i], vals[i]); end
            n_tests++; if (dbus_req_o !== 1'b0) begin n_fail++; $display("FAIL alu_noreq[%0d]: got %b want 0", i, dbus_req_o); end
        end
        idle_inputs();
    endtask

    task automatic test_stores();
        logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] adr [3] = '{32'h0000_0103, 32'h0000_0102, 32'h0000_0200};
        logic [31:0] dat [3] = '{32'h0000_00AB, 32'h1234_ABCD, 32'hCAFE_F00D};
        logic [31:0] ea  [3] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0200};
        logic [31:0] ewd [3] = '{32'hABAB_ABAB, 32'hABCD_ABCD, 32'hCAFE_F00D};
        logic [3:0]  ebe [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] d, a, w; logic we, dwe; logic [4:0] r; logic [3:0] be;
        int nv, nu, ns;
        for (int i = 0; i < 3; i++) begin
            mem_access(STORE, f3s[i], 5'd4, adr[i], dat[i], 32'h0, 0, 1, d, we, r, a, w, be, dwe, nv, nu, ns);
            n_tests++; if ({a, w, be, dwe} !== {ea[i], ewd[i], ebe[i], 1'b1}) begin n_fail++; $display("FAIL store_bus[%0d]: got addr %h wdata %h be %b we %b want %h %h %b 1", i, a, w, be, dwe, ea[i], ewd[i], ebe[i]); end
            n_tests++; if ({nv, we, nu, ns} !== {32'd1, 1'b0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL store_wb[%0d]: got valids %0d we %b unstable %0d stallbad %0d want 1 0 0 0", i, nv, we, nu, ns); end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011};
        logic [31:0] adr [7] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h104, 32'h101, 32'h108};
        logic [31:0] rdt [7] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                                 32'hDEAD_BEEF, 32'h0000_7F00, 32'h1234_5678};
        logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                 32'hDEAD_BEEF, 32'h0000_007F, 32'h1234_5678};
        logic [31:0] d, a, w; logic we, dwe; logic [4:0] r; logic [3:0] be;
        int nv, nu, ns;
        for (int i = 0; i < 7; i++) begin
            mem_access(LOAD, f3s[i], 5'd9, adr[i], 32'h0, rdt[i], 0, 1, d, we, r, a, w, be, dwe, nv, nu, ns);
            n_tests++; if ({d, we, r, dwe, a} !== {exp[i], 1'b1, 5'd9, 1'b0, {adr[i][31:2], 2'b00}}) begin n_fail++; $display("FAIL load[%0d]: got data %h we %b rd %0d buswe %b addr %h want %h 1 9 0", i, d, we, r, dwe, a, exp[i]); end
        end
        mem_access(LOAD, 3'b010, 5'd0, 32'h10, 32'h0, 32'h5555_AAAA, 0, 1, d, we, r, a, w, be, dwe, nv, nu, ns);
        n_tests++; if ({we, nv} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL load_rd0: got we %b valids %0d want 0 1", we, nv); end
    endtask

    task automatic test_gnt_wait();
        logic [31:0] d, a, w; logic we, dwe; logic [4:0] r; logic [3:0] be;
        int nv, nu, ns;
        mem_access(LOAD, 3'b010, 5'd12, 32'h40, 32'h0, 32'h0BAD_F00D, 4, 2, d, we, r, a, w, be, dwe, nv, nu, ns);
        n_tests++; if (nu !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d unstable samples want 0", nu); end
        n_tests++; if (ns !== 0) begin n_fail++; $display("FAIL wait_stall: got %0d bad stall samples want 0", ns); end
        n_tests++; if ({nv, d, we} !== {32'd1, 32'h0BAD_F00D, 1'b1}) begin n_fail++; $display("FAIL wait_wb: got valids %0d data %h we %b want 1 0badf00d 1", nv, d, we); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, a, w; logic we, dwe; logic [4:0] r; logic [3:0] be;
        int nv, nu, ns;
        mem_access(STORE, 3'b001, 5'd0, 32'h300, 32'h0000_BEEF, 32'h0, 1, 1, d, we, r, a, w, be, dwe, nv, nu, ns);
        mem_access(LOAD, 3'b101, 5'd2, 32'h302, 32'h0, 32'hBEEF_0000, 0, 3, d, we, r, a, w, be, dwe, nv, nu, ns);
        n_tests++; if ({d, we, nv, ns} !== {32'h0000_BEEF, 1'b1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL b2b_load: got data %h we %b valids %0d stallbad %0d want 0000beef 1 1 0", d, we, nv, ns); end
    endtask

    task automatic test_watchdog();
        int cyc = 0;
        int req_drop = 0;
        opcode_i = LOAD; funct3_i = 3'b010; rd_i = 5'd8; alu_out_i = 32'h80;
        @(posedge clk); #1;
        while (bus_err_o !== 1'b1 && cyc < 20) begin
            if (dbus_req_o !== 1'b1) req_drop++;
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++; if (cyc !== 8 || req_drop !== 0) begin n_fail++; $display("FAIL wdog_time: got bus_err after %0d cycles (req drops %0d) want 8 (0)", cyc, req_drop); end
        n_tests++; if ({wb_valid_o, wb_we_o, dbus_req_o} !== 3'b100) begin n_fail++; $display("FAIL wdog_wb: got valid %b we %b req %b want 1 0 0", wb_valid_o, wb_we_o, dbus_req_o); end
        idle_inputs();
        #1;
        n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL wdog_idle: got stall %b want 0", stall_o); end
        @(posedge clk); #1;
        n_tests++; if (bus_err_o !== 1'b0) begin n_fail++; $display("FAIL wdog_pulse: got bus_err %b want 0", bus_err_o); end
    endtask

    task automatic test_reset_mid_resp();
        opcode_i = LOAD; funct3_i = 3'b010; rd_i = 5'd6; alu_out_i = 32'h44;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b1;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
        rst = 1'b1;
        idle_inputs();
        #1;
        n_tests++; if ({dbus_req_o, wb_valid_o, stall_o, bus_err_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid: got req %b valid %b stall %b err %b want 0", dbus_req_o, wb_valid_o, stall_o, bus_err_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        alu_out_i = 32'h55;
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
        n_tests++; if ({wb_data_o, wb_we_o, stall_o, dbus_req_o} !== {32'h55, 3'b000}) begin n_fail++; $display("FAIL late_rvalid: got data %h we %b stall %b req %b want 00000055 0 0 0", wb_data_o, wb_we_o, stall_o, dbus_req_o); end
        idle_inputs();
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        logic [2:0]  f3s [2] = '{3'b010, 3'b001};
        logic [6:0]  ops [2] = '{LOAD, STORE};
        logic [31:0] adr [2] = '{32'h101, 32'h103};
        for (int i = 0; i < 2; i++) begin
            opcode_i = ops[i]; funct3_i = f3s[i]; rd_i = 5'd3; alu_out_i = adr[i];
            #1;
            n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mis_stall[%0d]: got %b want 0", i, stall_o); end
            @(posedge clk); #1;
            n_tests++; if ({misalign_o, wb_valid_o, wb_we_o, dbus_req_o} !== 4'b1100) begin n_fail++; $display("FAIL mis_trap[%0d]: got mis %b valid %b we %b req %b want 1 1 0 0", i, misalign_o, wb_valid_o, wb_we_o, dbus_req_o); end
            idle_inputs();
            @(posedge clk); #1;
            n_tests++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse[%0d]: got %b want 0", i, misalign_o); end
        end
`else
        logic [31:0] d, a, w; logic we, dwe; logic [4:0] r; logic [3:0] be;
        int nv, nu, ns;
        mem_access(LOAD, 3'b010, 5'd3, 32'h101, 32'h0, 32'hCAFE_BABE, 0, 1, d, we, r, a, w, be, dwe, nv, nu, ns);
        n_tests++; if ({a, d, misalign_o} !== {32'h100, 32'hCAFE_BABE, 1'b0}) begin n_fail++; $display("FAIL mis_lw: got addr %h data %h mis %b want 00000100 cafebabe 0", a, d, misalign_o); end
        mem_access(LOAD, 3'b001, 5'd3, 32'h103, 32'h0, 32'h8001_7FFF, 0, 1, d, we, r, a, w, be, dwe, nv, nu, ns);
        n_tests++; if ({d, misalign_o} !== {32'hFFFF_8001, 1'b0}) begin n_fail++; $display("FAIL mis_lh: got data %h mis %b want ffff8001 0", d, misalign_o); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_stores();
        test_loads();
        test_gnt_wait();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_resp();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
